multi_producer: RTL and testbench

MULTI_PRODUCER -- requirements
Module: multi_producer

---
 rtl/multi_producer.sv | 155 +++++++++++++++
 tb/tb_multi_producer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_producer.sv
// multi_producer: NUM_CH independent burst producers emitting address/ID items under a valid/stall handshake.
// Optional feature macro PRODUCER_STALL_CNT_EN adds per-channel saturating stall counters on stall_count.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module multi_producer #(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = `ADDRESS_WIDTH,
    parameter int ID_W      = `ID_WIDTH,
    parameter int SEQ_W     = 4,
    parameter int STRIDE    = 4,
    parameter int BURST_LEN = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        start,
    input  logic [NUM_CH-1:0]        in_stall,
    output logic [NUM_CH*ADDR_W-1:0] out_address,
    output logic [NUM_CH*ID_W-1:0]   out_id,
    output logic [NUM_CH-1:0]        out_valid,
    output logic [NUM_CH-1:0]        done,
    output logic                     busy
`ifdef PRODUCER_STALL_CNT_EN
    ,
    output logic [NUM_CH*16-1:0]     stall_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int TAG_W = ID_W - SEQ_W;
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] STRIDE_V = ADDR_W'(STRIDE);

    logic [NUM_CH-1:0] active_s;
    logic              busy_r;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [TAG_W-1:0] TAG = TAG_W'(c + 1);

        state_t            state_r, state_s;
        logic [ADDR_W-1:0] addr_r, addr_s;
        logic [ID_W-1:0]   id_r, id_s;
        logic [CNT_W-1:0]  cnt_r, cnt_s;
        logic              valid_r, valid_s;
        logic              done_r, done_s;

        // Next-state and next-output logic for one channel; the ID tag is fixed per channel.
        always_comb begin
            state_s = state_r;
            addr_s  = addr_r;
            id_s    = id_r;
            cnt_s   = cnt_r;
            valid_s = 1'b0;
            done_s  = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start[c]) begin
                        state_s = ST_ACTIVE;
                        addr_s  = {ADDR_W{1'b0}};
                        id_s    = {TAG, {SEQ_W{1'b0}}};
                        cnt_s   = {CNT_W{1'b0}};
                        valid_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (in_stall[c]) begin
                        valid_s = 1'b1;
                    end else if (cnt_r == LAST_CNT) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end else begin
                        addr_s  = addr_r + STRIDE_V;
                        id_s    = {TAG, id_r[SEQ_W-1:0] + SEQ_W'(1)};
                        cnt_s   = cnt_r + CNT_W'(1);
                        valid_s = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end

        // Channel state and registered outputs.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_r <= ST_IDLE;
                addr_r  <= {ADDR_W{1'b0}};
                id_r    <= {ID_W{1'b0}};
                cnt_r   <= {CNT_W{1'b0}};
                valid_r <= 1'b0;
                done_r  <= 1'b0;
            end else begin
                state_r <= state_s;
                addr_r  <= addr_s;
                id_r    <= id_s;
                cnt_r   <= cnt_s;
                valid_r <= valid_s;
                done_r  <= done_s;
            end
        end

`ifdef PRODUCER_STALL_CNT_EN
        logic [15:0] stall_cnt_r;

        // Saturating count of cycles an offered item is held back by the consumer.
        always_ff @(posedge clk) begin
            if (reset) begin
                stall_cnt_r <= 16'h0000;
            end else if ((state_r == ST_IDLE) && start[c]) begin
                stall_cnt_r <= 16'h0000;
            end else if (valid_r && in_stall[c] && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'h0001;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end

        assign stall_count[c*16 +: 16] = stall_cnt_r;
`endif

        assign active_s[c]                   = (state_s != ST_IDLE);
        assign out_address[c*ADDR_W +: ADDR_W] = addr_r;
        assign out_id[c*ID_W +: ID_W]          = id_r;
        assign out_valid[c]                    = valid_r;
        assign done[c]                         = done_r;
    end

    // Busy tracks the post-edge state of every channel so it is aligned with the channel outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= |active_s;
        end
    end

    assign busy = busy_r;

endmodule

// File: tb/tb_multi_producer.sv
// Bench for multi_producer: two instances (short bursts / wrapping bursts) checked every cycle
// against an index-based model, plus literal checks of the key scenarios.
module tb_multi_producer;

    localparam int NA = 2;
    localparam int NB = 3;

    logic clk = 1'b0;
    logic reset;
    logic [NA-1:0]    start_a, stall_a, valid_a, done_a;
    logic [NA*8-1:0]  addr_a, id_a;
    logic             busy_a;
    logic [NB-1:0]    start_b, stall_b, valid_b, done_b;
    logic [NB*6-1:0]  addr_b;
    logic [NB*8-1:0]  id_b;
    logic             busy_b;
`ifdef PRODUCER_STALL_CNT_EN
    logic [NA*16-1:0] sc_a;
    logic [NB*16-1:0] sc_b;
`endif

    always #5 clk = ~clk;

    multi_producer #(.NUM_CH(NA), .ADDR_W(8), .ID_W(8), .SEQ_W(4), .STRIDE(4), .BURST_LEN(4)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .in_stall(stall_a),
        .out_address(addr_a), .out_id(id_a), .out_valid(valid_a), .done(done_a), .busy(busy_a)
`ifdef PRODUCER_STALL_CNT_EN
        , .stall_count(sc_a)
`endif
    );

    multi_producer #(.NUM_CH(NB), .ADDR_W(6), .ID_W(8), .SEQ_W(4), .STRIDE(4), .BURST_LEN(20)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .in_stall(stall_b),
        .out_address(addr_b), .out_id(id_b), .out_valid(valid_b), .done(done_b), .busy(busy_b)
`ifdef PRODUCER_STALL_CNT_EN
        , .stall_count(sc_b)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    bit armed = 1'b0;

    // Model: per channel, whether a burst is running, how many items were taken, and a pending done.
    bit m_act [2][8];
    bit m_dn  [2][8];
    int m_k   [2][8];
    int m_sc  [2][8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int d, input int nch, input int bl,
                              input logic [7:0] st, input logic [7:0] sl, input logic rst);
        for (int c = 0; c < nch; c++) begin
            if (rst) begin
                m_act[d][c] = 1'b0; m_dn[d][c] = 1'b0; m_k[d][c] = 0; m_sc[d][c] = 0;
            end else if (m_dn[d][c]) begin
                m_dn[d][c] = 1'b0;
            end else if (m_act[d][c]) begin
                if (sl[c]) begin
                    if (m_sc[d][c] < 65535) m_sc[d][c]++;
                end else if (m_k[d][c] == bl - 1) begin
                    m_act[d][c] = 1'b0; m_dn[d][c] = 1'b1;
                end else begin
                    m_k[d][c]++;
                end
            end else if (st[c]) begin
                m_act[d][c] = 1'b1; m_k[d][c] = 0; m_sc[d][c] = 0;
            end
        end
    endtask

    function automatic logic [63:0] exp_addr(input int d, input int c);
        int aw = (d == 0) ? 8 : 6;
        return 64'((m_k[d][c] * 4) % (1 << aw));
    endfunction

    function automatic logic [63:0] exp_id(input int d, input int c);
        return 64'(((c + 1) << 4) | (m_k[d][c] % 16));
    endfunction

    function automatic logic [63:0] exp_busy(input int d, input int nch);
        bit b = 1'b0;
        for (int c = 0; c < nch; c++) b = b | m_act[d][c] | m_dn[d][c];
        return 64'(b);
    endfunction

    // Advance the model on every rising edge using the inputs the DUTs see at that edge.
    always @(posedge clk) begin
        model_step(0, NA, 4, 8'(start_a), 8'(stall_a), reset);
        model_step(1, NB, 20, 8'(start_b), 8'(stall_b), reset);
        if (reset) armed = 1'b1;
    end

    // Compare every output of both instances against the model on each falling edge.
    always @(negedge clk) begin
        if (armed) begin
            for (int c = 0; c < NA; c++) begin
                chk($sformatf("a.valid%0d", c), 64'(valid_a[c]), 64'(m_act[0][c]));
                chk($sformatf("a.done%0d", c), 64'(done_a[c]), 64'(m_dn[0][c]));
                if (m_act[0][c]) begin
                    chk($sformatf("a.addr%0d", c), 64'(addr_a[c*8 +: 8]), exp_addr(0, c));
                    chk($sformatf("a.id%0d", c), 64'(id_a[c*8 +: 8]), exp_id(0, c));
                end
`ifdef PRODUCER_STALL_CNT_EN
                chk($sformatf("a.stall_cnt%0d", c), 64'(sc_a[c*16 +: 16]), 64'(m_sc[0][c]));
`endif
            end
            for (int c = 0; c < NB; c++) begin
                chk($sformatf("b.valid%0d", c), 64'(valid_b[c]), 64'(m_act[1][c]));
                chk($sformatf("b.done%0d", c), 64'(done_b[c]), 64'(m_dn[1][c]));
                if (m_act[1][c]) begin
                    chk($sformatf("b.addr%0d", c), 64'(addr_b[c*6 +: 6]), exp_addr(1, c));
                    chk($sformatf("b.id%0d", c), 64'(id_b[c*8 +: 8]), exp_id(1, c));
                end
`ifdef PRODUCER_STALL_CNT_EN
                chk($sformatf("b.stall_cnt%0d", c), 64'(sc_b[c*16 +: 16]), 64'(m_sc[1][c]));
`endif
            end
            chk("a.busy", 64'(busy_a), exp_busy(0, NA));
            chk("b.busy", 64'(busy_b), exp_busy(1, NB));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [7:0] lit_addr [4];
    logic [7:0] lit_id   [4];

    initial begin
        lit_addr = '{8'h00, 8'h04, 8'h08, 8'h0C};
        lit_id   = '{8'h10, 8'h11, 8'h12, 8'h13};
        reset = 1'b1;
        start_a = '0; stall_a = '0; start_b = '0; stall_b = '0;
        tick(); tick();
        @(negedge clk);
        chk("lit.reset_valid", 64'(valid_a), 64'd0);
        chk("lit.reset_addr", 64'(addr_a), 64'd0);
        chk("lit.reset_id", 64'(id_a), 64'd0);
        chk("lit.reset_busy", 64'(busy_b), 64'd0);
        reset = 1'b0;
        tick();

        // Basic burst on channel 0 only.
        start_a = 2'b01;
        tick();
        start_a = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lit.burst_addr", 64'(addr_a[7:0]), 64'(lit_addr[i]));
            chk("lit.burst_id", 64'(id_a[7:0]), 64'(lit_id[i]));
            chk("lit.ch1_idle", 64'(valid_a[1]), 64'd0);
            tick();
        end
        @(negedge clk);
        chk("lit.done_pulse", 64'(done_a), 64'd1);
        tick();
        @(negedge clk);
        chk("lit.done_once", 64'(done_a), 64'd0);
        chk("lit.idle_busy", 64'(busy_a), 64'd0);

        // Three-cycle stall on item 2.
        start_a = 2'b01;
        tick();
        start_a = 2'b00;
        tick(); tick();
        stall_a = 2'b01;
        repeat (3) begin
            tick();
            @(negedge clk);
            chk("lit.stall_hold_addr", 64'(addr_a[7:0]), 64'h08);
            chk("lit.stall_hold_id", 64'(id_a[7:0]), 64'h12);
        end
        stall_a = 2'b00;
        tick();
        @(negedge clk);
        chk("lit.after_stall_addr", 64'(addr_a[7:0]), 64'h0C);
`ifdef PRODUCER_STALL_CNT_EN
        chk("lit.stall_count", 64'(sc_a[15:0]), 64'd3);
`endif
        repeat (3) tick();

        // Both channels started, channel 1 permanently stalled.
        start_a = 2'b11;
        stall_a = 2'b10;
        tick();
        start_a = 2'b00;
        repeat (6) tick();
        @(negedge clk);
        chk("lit.frozen_addr", 64'(addr_a[15:8]), 64'h00);
        chk("lit.frozen_id", 64'(id_a[15:8]), 64'h20);
        chk("lit.frozen_busy", 64'(busy_a), 64'd1);
        chk("lit.ch0_finished", 64'(valid_a[0]), 64'd0);
        stall_a = 2'b00;
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Reset mid-burst with start held high.
        start_a = 2'b01;
        tick();
        start_a = 2'b00;
        tick(); tick();
        reset = 1'b1;
        start_a = 2'b01;
        tick();
        @(negedge clk);
        chk("lit.midreset_valid", 64'(valid_a), 64'd0);
        chk("lit.midreset_done", 64'(done_a), 64'd0);
        chk("lit.midreset_addr", 64'(addr_a), 64'd0);
        chk("lit.midreset_id", 64'(id_a), 64'd0);
        reset = 1'b0;
        tick();
        start_a = 2'b00;
        @(negedge clk);
        chk("lit.restart_addr", 64'(addr_a[7:0]), 64'h00);
        chk("lit.restart_valid", 64'(valid_a[0]), 64'd1);
        repeat (6) tick();

        // start pulses during ACTIVE and DONE must be ignored.
        start_a = 2'b01; tick();
        start_a = 2'b00; tick();
        start_a = 2'b01; tick();
        start_a = 2'b00; tick(); tick();
        start_a = 2'b01; tick();
        start_a = 2'b00;
        @(negedge clk);
        chk("lit.ignored_valid", 64'(valid_a[0]), 64'd0);
        chk("lit.ignored_busy", 64'(busy_a), 64'd0);

        // Long burst with sequence and address wrap.
        start_b = 3'b001;
        tick();
        start_b = 3'b000;
        repeat (15) tick();
        @(negedge clk);
        chk("lit.item15_addr", 64'(addr_b[5:0]), 64'd60);
        chk("lit.item15_id", 64'(id_b[7:0]), 64'h1F);
        tick();
        @(negedge clk);
        chk("lit.item16_addr", 64'(addr_b[5:0]), 64'd0);
        chk("lit.item16_id", 64'(id_b[7:0]), 64'h10);
        repeat (6) tick();

        // Randomized traffic on both instances, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            start_a = NA'($urandom);
            stall_a = NA'($urandom) & NA'($urandom);
            start_b = NB'($urandom);
            stall_b = NB'($urandom) & NB'($urandom);
            reset   = ($urandom_range(0, 59) == 0);
            tick();
        end
        reset = 1'b0;
        start_a = '0; stall_a = '0; start_b = '0; stall_b = '0;
        repeat (30) tick();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
